// File: rtl/uflash_if.sv
// Command/response handshake between the MCU flash request logic and uflash_ctrl.
// The master issues read/program/erase commands; the slave returns a one-cycle response.
interface uflash_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_xadr;
  logic [5:0]  cmd_yadr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_xadr, cmd_yadr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_xadr, cmd_yadr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/uflash_ctrl.sv
// Strobe sequencer for the FLASH608K user flash macro: runs one read, program or
// page erase at a time with cycle-counted setup/hold phases; every output is registered.
module uflash_ctrl #(
  parameter int unsigned T_RD    = 2,
  parameter int unsigned T_NVS   = 135,
  parameter int unsigned T_PGS   = 270,
  parameter int unsigned T_PROG  = 324,
  parameter int unsigned T_PGH   = 2,
  parameter int unsigned T_NVH   = 135,
  parameter int unsigned T_RCV   = 270,
  parameter int unsigned T_ERASE = 162000,
  parameter int unsigned CNT_W   = 18
) (
  input  logic        clk,
  input  logic        rst,
  uflash_if.slave     bus,
  output logic [8:0]  uf_xadr,
  output logic [5:0]  uf_yadr,
  output logic [31:0] uf_din,
  output logic        uf_xe,
  output logic        uf_ye,
  output logic        uf_se,
  output logic        uf_prog,
  output logic        uf_erase,
  output logic        uf_nvstr,
  input  logic [31:0] uf_dout
);

  typedef enum logic [3:0] {
    IDLE, RD_SE, RD_WAIT,
    PG_NVS, PG_PGS, PG_PROG, PG_PGH, PG_NVH, PG_RCV,
    ER_NVS, ER_ERASE, ER_NVH, ER_RCV,
    ERR
  } state_t;

  // Each phase loads T-1 so that it lasts exactly T cycles.
  localparam logic [CNT_W-1:0] LD_RD    = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] LD_NVS   = CNT_W'(T_NVS - 1);
  localparam logic [CNT_W-1:0] LD_PGS   = CNT_W'(T_PGS - 1);
  localparam logic [CNT_W-1:0] LD_PROG  = CNT_W'(T_PROG - 1);
  localparam logic [CNT_W-1:0] LD_PGH   = CNT_W'(T_PGH - 1);
  localparam logic [CNT_W-1:0] LD_NVH   = CNT_W'(T_NVH - 1);
  localparam logic [CNT_W-1:0] LD_RCV   = CNT_W'(T_RCV - 1);
  localparam logic [CNT_W-1:0] LD_ERASE = CNT_W'(T_ERASE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_r, state_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic              cnt_zero, cnt_step;
  logic              xe_r, ye_r, se_r, prog_r, erase_r, nvstr_r;
  logic              xe_n, ye_n, se_n, prog_n, erase_n, nvstr_n;
  logic [8:0]        xadr_r, xadr_n;
  logic [5:0]        yadr_r, yadr_n;
  logic [31:0]       din_r, din_n;
  logic [31:0]       rdata_r, rdata_n;
  logic              rsp_valid_r, rsp_valid_n;
  logic              rsp_err_r, rsp_err_n;
  logic              ready_r, ready_n;
  logic              busy_r, busy_n;

  assign cnt_zero = (cnt_r == '0);

  // State, counter and all output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      xe_r        <= 1'b0;
      ye_r        <= 1'b0;
      se_r        <= 1'b0;
      prog_r      <= 1'b0;
      erase_r     <= 1'b0;
      nvstr_r     <= 1'b0;
      xadr_r      <= 9'd0;
      yadr_r      <= 6'd0;
      din_r       <= 32'd0;
      rdata_r     <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      xe_r        <= xe_n;
      ye_r        <= ye_n;
      se_r        <= se_n;
      prog_r      <= prog_n;
      erase_r     <= erase_n;
      nvstr_r     <= nvstr_n;
      xadr_r      <= xadr_n;
      yadr_r      <= yadr_n;
      din_r       <= din_n;
      rdata_r     <= rdata_n;
      rsp_valid_r <= rsp_valid_n;
      rsp_err_r   <= rsp_err_n;
      ready_r     <= ready_n;
      busy_r      <= busy_n;
    end
  end

  // Next-state and next-output logic; a wait phase advances when the counter hits 0.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    cnt_step    = 1'b0;
    xe_n        = xe_r;
    ye_n        = ye_r;
    se_n        = se_r;
    prog_n      = prog_r;
    erase_n     = erase_r;
    nvstr_n     = nvstr_r;
    xadr_n      = xadr_r;
    yadr_n      = yadr_r;
    din_n       = din_r;
    rdata_n     = rdata_r;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.cmd_valid && ready_r) begin
          xadr_n = bus.cmd_xadr;
          yadr_n = bus.cmd_yadr;
          din_n  = bus.cmd_wdata;
          case (bus.cmd_op)
            2'b00: begin state_n = RD_SE;  xe_n = 1'b1; ye_n = 1'b1; se_n = 1'b1; end
            2'b01: begin state_n = PG_NVS; cnt_n = LD_NVS; xe_n = 1'b1; prog_n  = 1'b1; end
            2'b10: begin state_n = ER_NVS; cnt_n = LD_NVS; xe_n = 1'b1; erase_n = 1'b1; end
            default: state_n = ERR;
          endcase
        end else begin
          state_n = IDLE;
        end
      end
      RD_SE: begin
        state_n = RD_WAIT;
        se_n    = 1'b0;
        cnt_n   = LD_RD;
      end
      RD_WAIT: begin
        if (cnt_zero) begin
          state_n = IDLE; rdata_n = uf_dout; xe_n = 1'b0; ye_n = 1'b0; rsp_valid_n = 1'b1;
        end else cnt_step = 1'b1;
      end
      PG_NVS: begin
        if (cnt_zero) begin state_n = PG_PGS; cnt_n = LD_PGS; nvstr_n = 1'b1; end
        else cnt_step = 1'b1;
      end
      PG_PGS: begin
        if (cnt_zero) begin state_n = PG_PROG; cnt_n = LD_PROG; ye_n = 1'b1; end
        else cnt_step = 1'b1;
      end
      PG_PROG: begin
        if (cnt_zero) begin state_n = PG_PGH; cnt_n = LD_PGH; ye_n = 1'b0; end
        else cnt_step = 1'b1;
      end
      PG_PGH: begin
        if (cnt_zero) begin state_n = PG_NVH; cnt_n = LD_NVH; prog_n = 1'b0; end
        else cnt_step = 1'b1;
      end
      PG_NVH: begin
        if (cnt_zero) begin state_n = PG_RCV; cnt_n = LD_RCV; nvstr_n = 1'b0; end
        else cnt_step = 1'b1;
      end
      PG_RCV: begin
        if (cnt_zero) begin state_n = IDLE; xe_n = 1'b0; rsp_valid_n = 1'b1; end
        else cnt_step = 1'b1;
      end
      ER_NVS: begin
        if (cnt_zero) begin state_n = ER_ERASE; cnt_n = LD_ERASE; nvstr_n = 1'b1; end
        else cnt_step = 1'b1;
      end
      ER_ERASE: begin
        if (cnt_zero) begin state_n = ER_NVH; cnt_n = LD_NVH; erase_n = 1'b0; end
        else cnt_step = 1'b1;
      end
      ER_NVH: begin
        if (cnt_zero) begin state_n = ER_RCV; cnt_n = LD_RCV; nvstr_n = 1'b0; end
        else cnt_step = 1'b1;
      end
      ER_RCV: begin
        if (cnt_zero) begin state_n = IDLE; xe_n = 1'b0; rsp_valid_n = 1'b1; end
        else cnt_step = 1'b1;
      end
      ERR: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b1;
      end
      default: begin
        state_n = IDLE;
        xe_n = 1'b0; ye_n = 1'b0; se_n = 1'b0;
        prog_n = 1'b0; erase_n = 1'b0; nvstr_n = 1'b0;
      end
    endcase

    if (cnt_step) begin
      cnt_n = cnt_r - CNT_ONE;
    end else begin
      cnt_n = cnt_n;
    end

    // Ready/busy are registered copies of the state being entered.
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  assign bus.cmd_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rdata_r;
  assign uf_xadr       = xadr_r;
  assign uf_yadr       = yadr_r;
  assign uf_din        = din_r;
  assign uf_xe         = xe_r;
  assign uf_ye         = ye_r;
  assign uf_se         = se_r;
  assign uf_prog       = prog_r;
  assign uf_erase      = erase_r;
  assign uf_nvstr      = nvstr_r;

endmodule

// File: tb/tb_uflash_ctrl.sv
// Directed bench for uflash_ctrl: reset, read, program, erase with a blocked second
// command, illegal op followed back-to-back by a read, and reset in the middle of an erase.
module tb_uflash_ctrl;
  logic        clk;
  logic        rst;
  logic [8:0]  uf_xadr;
  logic [5:0]  uf_yadr;
  logic [31:0] uf_din;
  logic        uf_xe, uf_ye, uf_se, uf_prog, uf_erase, uf_nvstr;
  logic [31:0] uf_dout;
  int          vectors;
  int          miscompares;
  logic [7:0]  exp_s;

  uflash_if bus();

  uflash_ctrl #(
    .T_RD(2), .T_NVS(3), .T_PGS(3), .T_PROG(3), .T_PGH(3),
    .T_NVH(3), .T_RCV(3), .T_ERASE(10), .CNT_W(18)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .uf_xadr(uf_xadr), .uf_yadr(uf_yadr), .uf_din(uf_din),
    .uf_xe(uf_xe), .uf_ye(uf_ye), .uf_se(uf_se),
    .uf_prog(uf_prog), .uf_erase(uf_erase), .uf_nvstr(uf_nvstr),
    .uf_dout(uf_dout)
  );

  // Macro read model: one fixed word, otherwise an address-derived pattern.
  assign uf_dout = (uf_xadr == 9'h005 && uf_yadr == 6'h11) ? 32'hDEADBEEF
                 : (32'hA5A50000 ^ {17'd0, uf_xadr, uf_yadr});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // {xe, ye, se, prog, erase, nvstr, rsp_valid, cmd_ready}
  function automatic logic [7:0] snap();
    return {uf_xe, uf_ye, uf_se, uf_prog, uf_erase, uf_nvstr, bus.rsp_valid, bus.cmd_ready};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [8:0] x,
                       input logic [5:0] y, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_xadr  = x;
    bus.cmd_yadr  = y;
    bus.cmd_wdata = d;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    drive(1'b0, 2'b00, 9'h000, 6'h00, 32'h0);

    // Reset: outputs forced low while rst is high
    #2 rst = 1'b1;
    #1;
    chk("rst_strobes", {24'd0, snap()}, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_ready", {24'd0, snap()}, {24'd0, 8'b0000_0001});
    chk("rst_busy_rel", {31'd0, bus.busy}, 32'd0);

    // Read at (005, 11)
    drive(1'b1, 2'b00, 9'h005, 6'h11, 32'h0);
    tick();
    drive(1'b0, 2'b00, 9'h000, 6'h00, 32'h0);
    chk("rd_c1", {24'd0, snap()}, {24'd0, 8'b1110_0000});
    chk("rd_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("rd_c2", {24'd0, snap()}, {24'd0, 8'b1100_0000});
    tick();
    chk("rd_c3", {24'd0, snap()}, {24'd0, 8'b1100_0000});
    tick();
    chk("rd_c4", {24'd0, snap()}, {24'd0, 8'b0000_0011});
    chk("rd_data", bus.rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", {31'd0, bus.rsp_err}, 32'd0);
    tick();
    chk("rd_c5", {24'd0, snap()}, {24'd0, 8'b0000_0001});
    chk("rd_hold", bus.rsp_rdata, 32'hDEADBEEF);

    // Program 12345678 at (001, 02), every phase 3 cycles
    drive(1'b1, 2'b01, 9'h001, 6'h02, 32'h12345678);
    tick();
    drive(1'b0, 2'b00, 9'h1FF, 6'h3F, 32'hFFFFFFFF);
    for (int k = 1; k <= 20; k++) begin
      exp_s = {(k <= 18), (k >= 7 && k <= 9), 1'b0, (k <= 12), 1'b0,
               (k >= 4 && k <= 15), (k == 19), (k >= 19)};
      chk($sformatf("pg_k%0d", k), {24'd0, snap()}, {24'd0, exp_s});
      chk($sformatf("pg_din_k%0d", k), uf_din, 32'h12345678);
      tick();
    end
    chk("pg_err", {31'd0, bus.rsp_err}, 32'd0);

    // Erase page 0AA; a read is held on cmd_valid the whole time
    drive(1'b1, 2'b10, 9'h0AA, 6'h07, 32'h0);
    tick();
    drive(1'b1, 2'b00, 9'h006, 6'h01, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      exp_s = {(k <= 19), 1'b0, 1'b0, 1'b0, (k <= 13),
               (k >= 4 && k <= 16), (k == 20), (k == 20)};
      chk($sformatf("er_k%0d", k), {24'd0, snap()}, {24'd0, exp_s});
      chk($sformatf("er_xadr_k%0d", k), {23'd0, uf_xadr}, {23'd0, 9'h0AA});
      tick();
    end
    drive(1'b0, 2'b00, 9'h000, 6'h00, 32'h0);
    chk("er_rd_acc", {24'd0, snap()}, {24'd0, 8'b1110_0000});
    chk("er_rd_xadr", {23'd0, uf_xadr}, {23'd0, 9'h006});
    tick(); tick(); tick();
    chk("er_rd_rsp", {24'd0, snap()}, {24'd0, 8'b0000_0011});
    chk("er_rd_data", bus.rsp_rdata, 32'hA5A50181);

    // Illegal op held, then read accepted in the response cycle
    drive(1'b1, 2'b11, 9'h033, 6'h05, 32'h0);
    tick();
    drive(1'b1, 2'b00, 9'h005, 6'h11, 32'h0);
    chk("il_c1", {24'd0, snap()}, 32'h0);
    chk("il_busy", {31'd0, bus.busy}, 32'd1);
    chk("il_xadr", {23'd0, uf_xadr}, {23'd0, 9'h033});
    tick();
    chk("il_c2", {24'd0, snap()}, {24'd0, 8'b0000_0011});
    chk("il_err", {31'd0, bus.rsp_err}, 32'd1);
    tick();
    drive(1'b0, 2'b00, 9'h000, 6'h00, 32'h0);
    chk("b2b_c1", {24'd0, snap()}, {24'd0, 8'b1110_0000});
    chk("b2b_err", {31'd0, bus.rsp_err}, 32'd0);
    tick(); tick(); tick();
    chk("b2b_rsp", {24'd0, snap()}, {24'd0, 8'b0000_0011});
    chk("b2b_data", bus.rsp_rdata, 32'hDEADBEEF);
    chk("b2b_err2", {31'd0, bus.rsp_err}, 32'd0);

    // Reset in ER_ERASE
    drive(1'b1, 2'b10, 9'h0AA, 6'h07, 32'h0);
    tick();
    drive(1'b0, 2'b00, 9'h000, 6'h00, 32'h0);
    for (int k = 1; k < 6; k++) tick();
    chk("mre_pre", {24'd0, snap()}, {24'd0, 8'b1000_1100});
    rst = 1'b1;
    #1;
    chk("mre_drop", {24'd0, snap()}, 32'h0);
    chk("mre_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mre_idle", {24'd0, snap()}, {24'd0, 8'b0000_0001});
    tick();
    chk("mre_norsp", {24'd0, snap()}, {24'd0, 8'b0000_0001});
    drive(1'b1, 2'b00, 9'h005, 6'h11, 32'h0);
    tick();
    drive(1'b0, 2'b00, 9'h000, 6'h00, 32'h0);
    chk("mre_rd_c1", {24'd0, snap()}, {24'd0, 8'b1110_0000});
    tick(); tick(); tick();
    chk("mre_rd_rsp", {24'd0, snap()}, {24'd0, 8'b0000_0011});
    chk("mre_rd_data", bus.rsp_rdata, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uflash_ctrl.md
Name: uflash_ctrl

Overview:
- Sequencer for the on-chip user flash macro (FLASH608K). It sits between the MCU's flash request logic and the `uf_*` pins.
- Accepts one read, program or page-erase command at a time through a valid/ready handshake.
- Generates the XE/YE/SE/PROG/ERASE/NVSTR strobe sequence with cycle-counted setup and hold times, then returns read data or completion on a one-cycle response strobe.
- Software never drives flash strobes directly.

Parameters:
- T_RD, 2: cycles from the SE pulse to sampling `uf_dout`.
- T_NVS, 135: PROG/ERASE-to-NVSTR setup (5 us at 27 MHz).
- T_PGS, 270: NVSTR-to-YE setup for program.
- T_PROG, 324: YE pulse width during program.
- T_PGH, 2: YE-fall-to-PROG-fall hold.
- T_NVH, 135: PROG/ERASE-fall-to-NVSTR-fall hold.
- T_RCV, 270: NVSTR-fall-to-XE-fall recovery.
- T_ERASE, 162000: ERASE+NVSTR hold time for a page erase.
- CNT_W, 18: wait-counter width. Every T_* must be at least 1 and at most 2^CNT_W-1.

Ports:
- clk  in  1  system clock; the single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  operation: 00 read, 01 program, 10 page erase, 11 illegal.
- cmd_xadr  in  9  flash row/page address.
- cmd_yadr  in  6  flash column (word) address.
- cmd_wdata  in  32  program data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  32  read data; valid when rsp_valid is high and the op was a read.
- rsp_err  out  1  qualifies rsp_valid: illegal op.
- busy  out  1  high whenever state is not IDLE.
- uf_xadr  out  9  to macro.
- uf_yadr  out  6  to macro.
- uf_din  out  32  to macro.
- uf_xe, uf_ye, uf_se, uf_prog, uf_erase, uf_nvstr  out  1 each  macro strobes.
- uf_dout  in  32  macro read data.

Behaviour:
- **Registers:** all outputs are registered. On rst every output is 0, the state is IDLE and the counter is 0, asynchronously. A reset mid-program or mid-erase drops all strobes at once; the contents of the affected page are then undefined, and this is accepted.
- **Handshake:**
  - cmd_ready = (state==IDLE).
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - On acceptance, cmd_xadr, cmd_yadr and cmd_wdata are latched into uf_xadr, uf_yadr and uf_din, and held unchanged until the next acceptance.
  - cmd_* is ignored while busy.
- **Response:** rsp_valid is high for exactly the first IDLE cycle after an operation completes. rsp_rdata holds its value until the next read completes. A new command may be accepted in that same cycle (back-to-back allowed).
- **Wait phases:** each wait phase lasts exactly its T_* cycles. The counter loads T_*-1 on phase entry and the phase advances on the edge where the counter equals 0.
- **Read** (states RD_SE, RD_WAIT):
  - Accept edge: XE=YE=SE=1.
  - RD_SE lasts 1 cycle, after which SE=0.
  - RD_WAIT lasts T_RD cycles. On its last edge uf_dout is captured into rsp_rdata, XE and YE are cleared, and rsp_valid=1.
  - With T_RD=2, rsp_valid is high in the 4th cycle after the accept edge.
- **Program** (states PG_NVS, PG_PGS, PG_PROG, PG_PGH, PG_NVH, PG_RCV):
  - Accept edge: XE=1, PROG=1; enter PG_NVS (T_NVS).
  - Then NVSTR=1; PG_PGS (T_PGS).
  - Then YE=1; PG_PROG (T_PROG).
  - Then YE=0; PG_PGH (T_PGH).
  - Then PROG=0; PG_NVH (T_NVH).
  - Then NVSTR=0; PG_RCV (T_RCV).
  - Then XE=0, enter IDLE, rsp_valid=1.
  - SE stays 0 throughout.
- **Erase** (states ER_NVS, ER_ERASE, ER_NVH, ER_RCV):
  - Accept edge: XE=1, ERASE=1; ER_NVS (T_NVS).
  - Then NVSTR=1; ER_ERASE (T_ERASE).
  - Then ERASE=0; ER_NVH (T_NVH).
  - Then NVSTR=0; ER_RCV (T_RCV).
  - Then XE=0, IDLE, rsp_valid=1.
  - YE, SE and uf_yadr are don't-care to the macro but are held.
- **Illegal op 11:** accepted. No strobe toggles. State ERR lasts 1 cycle, then IDLE with rsp_valid=1, rsp_err=1. rsp_err is 0 on all other responses.
- **Invariants:**
  - PROG and ERASE are never high together.
  - NVSTR is never high without PROG or ERASE having been high for at least T_NVS cycles.
  - No strobe is high while in IDLE.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, cmd_ready=1 after release, busy=0.
- Read: T_RD=2, uf_dout model returns 32'hDEADBEEF for (xadr 9'h005, yadr 6'h11) -> SE high exactly 1 cycle, rsp_valid on 4th cycle after accept, rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Program with all T_*=3, data 32'h12345678 at xadr 9'h001, yadr 6'h02:
  - Strobe edges occur exactly 3 cycles apart in order PROG↑, NVSTR↑, YE↑, YE↓, PROG↓, NVSTR↓, XE↓.
  - uf_din is stable throughout; rsp_valid after 19 cycles total; cmd_ready=0 throughout.
- Erase with T_ERASE=10, others 3 -> ERASE high 13 cycles, NVSTR high 13 cycles, one rsp_valid; a second cmd_valid during the erase is not accepted until IDLE.
- Back-to-back and illegal: hold cmd_valid with op 11, then read -> rsp_err=1 one cycle after accept with no strobe activity; the read is accepted in the rsp_valid cycle.
- Reset mid-erase: rst asserted in ER_ERASE -> ERASE, NVSTR and XE fall asynchronously; no rsp_valid; next read completes normally.
